// File: rtl/click_arbiter_ctl.sv
// Mouse click arbiter: hit-tests the cursor against N_RECT rectangles, picks the
// lowest-index hit, and reports a click only for press and release on the same rectangle.
module click_arbiter_ctl #(
  parameter int N_RECT = 4,
  parameter int IDX_W  = 2
) (
  input  logic                  pclk,
  input  logic                  rst,
  input  logic [11:0]           mouse_xpos,
  input  logic [11:0]           mouse_ypos,
  input  logic                  mouse_left,
  input  logic [11*N_RECT-1:0]  rect_hstart,
  input  logic [11*N_RECT-1:0]  rect_vstart,
  input  logic [11*N_RECT-1:0]  rect_hlength,
  input  logic [11*N_RECT-1:0]  rect_vlength,
  input  logic [N_RECT-1:0]     rect_enable,
  output logic                  hover_valid,
  output logic [IDX_W-1:0]      hover_idx,
  output logic                  press_active,
  output logic [N_RECT-1:0]     click_pulse,
  output logic                  sel_valid,
  output logic [IDX_W-1:0]      sel_idx
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARMED   = 2'd1,
    S_BLOCKED = 2'd2
  } state_t;

  logic [N_RECT-1:0] hit_d, hit_q;
  logic              left_q, left_p;
  logic [11:0]       h_lo, h_hi, v_lo, v_hi;

  // Stage 1: hit test of the live inputs, button level and its history
  always_comb begin
    hit_d = '0;
    h_lo  = '0;
    h_hi  = '0;
    v_lo  = '0;
    v_hi  = '0;
    for (int k = 0; k < N_RECT; k++) begin
      // 11-bit operands widened to 12 bits so the far edge never wraps
      h_lo     = {1'b0, rect_hstart[11*k +: 11]};
      h_hi     = h_lo + {1'b0, rect_hlength[11*k +: 11]};
      v_lo     = {1'b0, rect_vstart[11*k +: 11]};
      v_hi     = v_lo + {1'b0, rect_vlength[11*k +: 11]};
      hit_d[k] = rect_enable[k] &
                 (mouse_xpos >= h_lo) & (mouse_xpos <= h_hi) &
                 (mouse_ypos >= v_lo) & (mouse_ypos <= v_hi);
    end
  end

  // Button history resets high so a button held through reset is not a press
  always_ff @(posedge pclk) begin
    if (rst) begin
      hit_q  <= '0;
      left_q <= 1'b1;
      left_p <= 1'b1;
    end else begin
      hit_q  <= hit_d;
      left_q <= mouse_left;
      left_p <= left_q;
    end
  end

  logic             rise, fall;
  logic             win_valid;
  logic [IDX_W-1:0] win_idx;

  assign rise = left_q & ~left_p;
  assign fall = ~left_q & left_p;

  always_comb begin
    win_valid = 1'b0;
    win_idx   = '0;
    for (int k = N_RECT - 1; k >= 0; k--) begin
      if (hit_q[k]) begin
        win_valid = 1'b1;
        win_idx   = IDX_W'(k);
      end
    end
  end

  state_t            state_d, state_q;
  logic [IDX_W-1:0]  arm_idx_d, arm_idx_q;
  logic [N_RECT-1:0] click_pulse_d, click_pulse_q;
  logic              sel_valid_d, sel_valid_q;
  logic [IDX_W-1:0]  sel_idx_d, sel_idx_q;
  logic              hover_valid_d, hover_valid_q;
  logic [IDX_W-1:0]  hover_idx_d, hover_idx_q;

  // Stage 2: press/release FSM and registered outputs
  always_comb begin
    state_d       = state_q;
    arm_idx_d     = arm_idx_q;
    click_pulse_d = '0;
    sel_valid_d   = sel_valid_q;
    sel_idx_d     = sel_idx_q;
    hover_valid_d = win_valid;
    hover_idx_d   = win_idx;
    unique case (state_q)
      S_IDLE: begin
        if (rise && win_valid) begin
          state_d   = S_ARMED;
          arm_idx_d = win_idx;
        end else if (rise) begin
          state_d = S_BLOCKED;
        end
      end
      S_ARMED: begin
        // Release is judged on the armed rectangle itself, not the current winner
        if (!rect_enable[arm_idx_q]) begin
          state_d = S_BLOCKED;
        end else if (fall) begin
          state_d = S_IDLE;
          if (hit_q[arm_idx_q]) begin
            click_pulse_d[arm_idx_q] = 1'b1;
            sel_valid_d              = 1'b1;
            sel_idx_d                = arm_idx_q;
          end
        end
      end
      S_BLOCKED: begin
        if (!left_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      arm_idx_q     <= '0;
      click_pulse_q <= '0;
      sel_valid_q   <= 1'b0;
      sel_idx_q     <= '0;
      hover_valid_q <= 1'b0;
      hover_idx_q   <= '0;
    end else begin
      state_q       <= state_d;
      arm_idx_q     <= arm_idx_d;
      click_pulse_q <= click_pulse_d;
      sel_valid_q   <= sel_valid_d;
      sel_idx_q     <= sel_idx_d;
      hover_valid_q <= hover_valid_d;
      hover_idx_q   <= hover_idx_d;
    end
  end

  assign press_active = (state_q == S_ARMED);
  assign click_pulse  = click_pulse_q;
  assign sel_valid    = sel_valid_q;
  assign sel_idx      = sel_idx_q;
  assign hover_valid  = hover_valid_q;
  assign hover_idx    = hover_idx_q;

endmodule

// File: tb/tb_click_arbiter_ctl.sv
// Bench for click_arbiter_ctl: vector table, directed corner sequences and a
// randomized run against an abstract click model.
module tb_click_arbiter_ctl;

  localparam int N = 4;

  logic          pclk = 1'b0;
  logic          rst;
  logic [11:0]   mouse_xpos, mouse_ypos;
  logic          mouse_left;
  logic [43:0]   rect_hstart, rect_vstart, rect_hlength, rect_vlength;
  logic [3:0]    rect_enable;
  logic          hover_valid;
  logic [1:0]    hover_idx;
  logic          press_active;
  logic [3:0]    click_pulse;
  logic          sel_valid;
  logic [1:0]    sel_idx;

  click_arbiter_ctl #(.N_RECT(4), .IDX_W(2)) dut (
    .pclk(pclk), .rst(rst),
    .mouse_xpos(mouse_xpos), .mouse_ypos(mouse_ypos), .mouse_left(mouse_left),
    .rect_hstart(rect_hstart), .rect_vstart(rect_vstart),
    .rect_hlength(rect_hlength), .rect_vlength(rect_vlength),
    .rect_enable(rect_enable),
    .hover_valid(hover_valid), .hover_idx(hover_idx), .press_active(press_active),
    .click_pulse(click_pulse), .sel_valid(sel_valid), .sel_idx(sel_idx)
  );

  always #5 pclk = ~pclk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic set_rect(input int k, input int x, input int y, input int w, input int h);
    rect_hstart[11*k +: 11]  = 11'(x);
    rect_vstart[11*k +: 11]  = 11'(y);
    rect_hlength[11*k +: 11] = 11'(w);
    rect_vlength[11*k +: 11] = 11'(h);
  endtask

  // Directed stepping with accumulated observations
  logic [3:0] cp_or;
  logic       pa_or;

  task automatic clr();
    cp_or = '0;
    pa_or = 1'b0;
  endtask

  task automatic run(input int x, input int y, input logic l, input logic [3:0] en, input int n);
    for (int i = 0; i < n; i++) begin
      mouse_xpos  = 12'(x);
      mouse_ypos  = 12'(y);
      mouse_left  = l;
      rect_enable = en;
      @(posedge pclk);
      #1;
      cp_or = cp_or | click_pulse;
      pa_or = pa_or | press_active;
    end
  endtask

  // Abstract model: which rectangle (if any) owns the current press
  logic [3:0] m_hitq;
  logic       m_lq, m_lp;
  int         m_owner;     // -1: no press owned
  logic       m_dead;      // press began off-target or was cancelled; wait for release
  logic       e_hv, e_pa, e_sv;
  int         e_hi, e_si;
  logic [3:0] e_cp;

  function automatic logic [3:0] m_hits(input int x, input int y, input logic [3:0] en);
    logic [3:0] r;
    r = '0;
    for (int k = 0; k < N; k++) begin
      int hs, vs, hl, vl;
      hs = int'(rect_hstart[11*k +: 11]);
      vs = int'(rect_vstart[11*k +: 11]);
      hl = int'(rect_hlength[11*k +: 11]);
      vl = int'(rect_vlength[11*k +: 11]);
      r[k] = en[k] && x >= hs && x <= hs + hl && y >= vs && y <= vs + vl;
    end
    return r;
  endfunction

  task automatic model_edge();
    int  top;
    bit  pressed, released;
    if (rst) begin
      m_hitq = '0; m_lq = 1'b1; m_lp = 1'b1;
      m_owner = -1; m_dead = 1'b0;
      e_hv = 0; e_hi = 0; e_pa = 0; e_cp = '0; e_sv = 0; e_si = 0;
      return;
    end
    top = -1;
    for (int k = N - 1; k >= 0; k--) if (m_hitq[k]) top = k;
    pressed  = m_lq && !m_lp;
    released = !m_lq && m_lp;
    e_cp = '0;
    if (m_owner >= 0) begin
      if (!rect_enable[m_owner]) begin
        m_owner = -1;
        m_dead  = 1'b1;
      end else if (released) begin
        if (m_hitq[m_owner]) begin
          e_cp = 4'(1 << m_owner);
          e_sv = 1;
          e_si = m_owner;
        end
        m_owner = -1;
      end
    end else if (m_dead) begin
      if (!m_lq) m_dead = 1'b0;
    end else if (pressed) begin
      if (top >= 0) m_owner = top;
      else m_dead = 1'b1;
    end
    e_hv = (top >= 0);
    e_hi = (top >= 0) ? top : 0;
    e_pa = (m_owner >= 0);
    m_hitq = m_hits(int'(mouse_xpos), int'(mouse_ypos), rect_enable);
    m_lp   = m_lq;
    m_lq   = mouse_left;
  endtask

  typedef struct {
    logic       rst;
    int         x, y;
    logic       left;
    logic [3:0] en;
    logic       hv;
    int         hi;
    logic       pa;
    logic [3:0] cp;
    logic       sv;
    int         si;
  } vec_t;

  vec_t tbl[17];

  initial begin
    rst = 1'b1; mouse_xpos = '0; mouse_ypos = '0; mouse_left = 1'b0;
    rect_hstart = '0; rect_vstart = '0; rect_hlength = '0; rect_vlength = '0;
    rect_enable = 4'hF;
    set_rect(0, 100, 100, 50, 50);
    set_rect(1, 120, 120, 50, 50);
    set_rect(2, 300, 100, 40, 40);
    set_rect(3, 400, 400, 20, 20);

    //          rst  x    y    l  en      hv hi pa cp   sv si
    tbl[0]  = '{1,   0,   0,   0, 4'hF,   0, 0, 0, 4'h0, 0, 0};
    tbl[1]  = '{0, 125, 125,   0, 4'hF,   0, 0, 0, 4'h0, 0, 0};
    tbl[2]  = '{0, 125, 125,   1, 4'hF,   1, 0, 0, 4'h0, 0, 0};
    tbl[3]  = '{0, 125, 125,   1, 4'hF,   1, 0, 1, 4'h0, 0, 0};
    tbl[4]  = '{0, 125, 125,   1, 4'hF,   1, 0, 1, 4'h0, 0, 0};
    tbl[5]  = '{0, 125, 125,   0, 4'hF,   1, 0, 1, 4'h0, 0, 0};
    tbl[6]  = '{0, 125, 125,   0, 4'hF,   1, 0, 0, 4'h1, 1, 0};
    tbl[7]  = '{0, 125, 125,   0, 4'hF,   1, 0, 0, 4'h0, 1, 0};
    tbl[8]  = '{0, 160, 160,   0, 4'hF,   1, 0, 0, 4'h0, 1, 0};
    tbl[9]  = '{0, 160, 160,   1, 4'hF,   1, 1, 0, 4'h0, 1, 0};
    tbl[10] = '{0, 160, 160,   0, 4'hF,   1, 1, 1, 4'h0, 1, 0};
    tbl[11] = '{0, 160, 160,   0, 4'hF,   1, 1, 0, 4'h2, 1, 1};
    tbl[12] = '{0, 150, 150,   0, 4'h1,   1, 1, 0, 4'h0, 1, 1};
    tbl[13] = '{0, 151, 150,   0, 4'h1,   1, 0, 0, 4'h0, 1, 1};
    tbl[14] = '{0, 100,  99,   0, 4'h1,   0, 0, 0, 4'h0, 1, 1};
    tbl[15] = '{0, 100, 100,   0, 4'h1,   0, 0, 0, 4'h0, 1, 1};
    tbl[16] = '{0, 100, 100,   0, 4'hF,   1, 0, 0, 4'h0, 1, 1};

    @(negedge pclk);
    for (int r = 0; r < 17; r++) begin
      rst         = tbl[r].rst;
      mouse_xpos  = 12'(tbl[r].x);
      mouse_ypos  = 12'(tbl[r].y);
      mouse_left  = tbl[r].left;
      rect_enable = tbl[r].en;
      @(posedge pclk);
      #1;
      chk($sformatf("tbl%0d_hover_valid", r), int'(hover_valid), int'(tbl[r].hv));
      chk($sformatf("tbl%0d_hover_idx", r), int'(hover_idx), tbl[r].hi);
      chk($sformatf("tbl%0d_press_active", r), int'(press_active), int'(tbl[r].pa));
      chk($sformatf("tbl%0d_click_pulse", r), int'(click_pulse), int'(tbl[r].cp));
      chk($sformatf("tbl%0d_sel_valid", r), int'(sel_valid), int'(tbl[r].sv));
      chk($sformatf("tbl%0d_sel_idx", r), int'(sel_idx), tbl[r].si);
    end

    // Drag off the armed rectangle before release
    clr(); run(125, 125, 0, 4'hF, 2); run(125, 125, 1, 4'hF, 3);
    chk("drag_off_armed", int'(pa_or), 1);
    run(300, 300, 1, 4'hF, 3); run(300, 300, 0, 4'hF, 4);
    chk("drag_off_click", int'(cp_or), 0);
    chk("drag_off_sel", int'(sel_idx), 1);

    // Press outside, drag onto rect0, release
    clr(); run(50, 50, 0, 4'hF, 2); run(50, 50, 1, 4'hF, 2);
    run(125, 125, 1, 4'hF, 3); run(125, 125, 0, 4'hF, 4);
    chk("blocked_click", int'(cp_or), 0);
    chk("blocked_armed", int'(pa_or), 0);

    // Disable the armed rectangle while held
    clr(); run(320, 120, 0, 4'hF, 2); run(320, 120, 1, 4'hF, 3);
    chk("dis_armed", int'(press_active), 1);
    run(320, 120, 1, 4'hB, 1);
    chk("dis_cancel", int'(press_active), 0);
    run(320, 120, 0, 4'hB, 1); run(320, 120, 0, 4'hF, 3);
    chk("dis_click", int'(cp_or), 0);
    clr(); run(320, 120, 1, 4'hF, 2); run(320, 120, 0, 4'hF, 3);
    chk("after_dis_click", int'(cp_or), 4);
    chk("after_dis_sel", int'(sel_idx), 2);

    // Reset mid-press with the button held, then release
    clr(); run(410, 410, 1, 4'hF, 3);
    chk("rst_pre_armed", int'(press_active), 1);
    rst = 1'b1; run(410, 410, 1, 4'hF, 2); rst = 1'b0;
    chk("rst_hover_valid", int'(hover_valid), 0);
    chk("rst_press_active", int'(press_active), 0);
    chk("rst_sel_valid", int'(sel_valid), 0);
    chk("rst_sel_idx", int'(sel_idx), 0);
    clr(); run(410, 410, 1, 4'hF, 3); run(410, 410, 0, 4'hF, 3);
    chk("rst_held_click", int'(cp_or), 0);
    chk("rst_held_armed", int'(pa_or), 0);
    clr(); run(410, 410, 1, 4'hF, 2); run(410, 410, 0, 4'hF, 3);
    chk("rect3_click", int'(cp_or), 8);
    chk("rect3_sel_idx", int'(sel_idx), 3);
    chk("rect3_sel_valid", int'(sel_valid), 1);

    // Randomized run against the model
    rst = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      if (c % 500 == 0) begin
        for (int k = 0; k < N; k++)
          set_rect(k, $urandom_range(0, 600), $urandom_range(0, 600),
                   $urandom_range(0, 200), $urandom_range(0, 200));
      end
      if (c > 0) rst = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 3) == 0) begin
        if ($urandom_range(0, 7) == 0) begin
          mouse_xpos = 12'($urandom_range(0, 4095));
          mouse_ypos = 12'($urandom_range(0, 4095));
        end else begin
          int k, x, y;
          k = $urandom_range(0, N - 1);
          x = int'(rect_hstart[11*k +: 11]) + $urandom_range(0, int'(rect_hlength[11*k +: 11]) + 2) - 1;
          y = int'(rect_vstart[11*k +: 11]) + $urandom_range(0, int'(rect_vlength[11*k +: 11]) + 2) - 1;
          mouse_xpos = 12'((x < 0) ? 0 : x);
          mouse_ypos = 12'((y < 0) ? 0 : y);
        end
      end
      if ($urandom_range(0, 4) == 0) mouse_left = ~mouse_left;
      if ($urandom_range(0, 29) == 0) rect_enable[$urandom_range(0, N - 1)] ^= 1'b1;
      @(posedge pclk);
      model_edge();
      #1;
      chk("rnd_hover_valid", int'(hover_valid), int'(e_hv));
      chk("rnd_hover_idx", int'(hover_idx), e_hi);
      chk("rnd_press_active", int'(press_active), int'(e_pa));
      chk("rnd_click_pulse", int'(click_pulse), int'(e_cp));
      chk("rnd_sel_valid", int'(sel_valid), int'(e_sv));
      chk("rnd_sel_idx", int'(sel_idx), e_si);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/click_arbiter_ctl.md
# click_arbiter_ctl

Hit-tests the mouse cursor against up to N_RECT on-screen rectangles and arbitrates overlapping hits by fixed priority. Runs a press/release state machine so that a click is reported only when the left button is pressed and released on the same rectangle. Emits a one-cycle click pulse and a latched selection. Sits between the mouse controller outputs and the drawing/game logic, and replaces per-rectangle click latches.

## Interface
- N_RECT, default 4: number of rectangles; index 0 has the highest priority.
- IDX_W, default 2: index width, $clog2(N_RECT), minimum 1.

Ports:
- pclk  in  1  pixel clock; all logic is rising-edge.
- rst  in  1  reset, synchronous, active-high.
- mouse_xpos  in  12  cursor x.
- mouse_ypos  in  12  cursor y.
- mouse_left  in  1  left button level, already in the pclk domain.
- rect_hstart  in  11*N_RECT  packed x origins; rect k is at bits [11k+10:11k].
- rect_vstart  in  11*N_RECT  packed y origins.
- rect_hlength  in  11*N_RECT  packed widths.
- rect_vlength  in  11*N_RECT  packed heights.
- rect_enable  in  N_RECT  per-rectangle enable. A disabled rectangle never hits.
- hover_valid  out  1  cursor is over at least one enabled rectangle.
- hover_idx  out  IDX_W  highest-priority hovered index.
- press_active  out  1  FSM is in ARMED.
- click_pulse  out  N_RECT  one-hot, high for exactly one cycle per completed click.
- sel_valid  out  1  a selection exists.
- sel_idx  out  IDX_W  index of the last clicked rectangle.

## Operation
- **Hit test.** hit[k] = rect_enable[k] & (x >= hstart_k) & (x <= hstart_k + hlength_k) & (y >= vstart_k) & (y <= vstart_k + vlength_k).
  - All bounds are inclusive.
  - Sums are 12-bit, zero-extended, so they cannot wrap (max 4094).
  - Comparisons are unsigned.
- **Stage 1 (registered).**
  - hit_q[N_RECT-1:0] holds hit[].
  - left_q holds mouse_left.
  - left_p holds the previous left_q.
- **Edge detection.**
  - rise = left_q & ~left_p.
  - fall = ~left_q & left_p.
- **Priority encoding.** Lowest set index of hit_q gives win_idx and win_valid.
- **FSM states:** IDLE, ARMED, BLOCKED.
  - IDLE
    - rise & win_valid → ARMED, capturing arm_idx = win_idx.
    - rise & ~win_valid → BLOCKED.
    - Otherwise stay.
  - ARMED
    - If rect_enable[arm_idx] = 0 → BLOCKED, with no click. This check has priority over fall.
    - Else if fall & hit_q[arm_idx] → IDLE. Pulse click_pulse[arm_idx], set sel_idx = arm_idx, set sel_valid = 1.
    - Else if fall → IDLE with no click.
    - The cursor may leave and re-enter the armed rectangle while the button is held. Only the position at release counts.
    - Release is checked against hit_q[arm_idx], not win_idx. An armed lower-priority rectangle still clicks when overlapped by a higher-priority one.
  - BLOCKED
    - ~left_q → IDLE.
    - A press that starts outside every rectangle can never produce a click.
- **sel_idx / sel_valid** hold until the next click or rst. Clicking the already-selected rectangle re-pulses click_pulse; sel is unchanged.
- **Reset values**
  - State: IDLE; arm_idx = 0.
  - Stage-1 registers: hit_q = 0, left_q = 1, left_p = 1.
  - Outputs: hover_valid = 0, hover_idx = 0, press_active = 0, click_pulse = 0, sel_valid = 0, sel_idx = 0.
- **Button held through reset.** left_q/left_p reset to 1, so no false rise is seen. The held button produces no click until it is released and pressed again.

## Timing
- Inputs are sampled at edge E0 into stage 1. The FSM and all outputs are registered at E1. Input-to-output latency is 2 pclk edges.
- click_pulse is high for exactly one cycle. It is never high while sel_valid is still updating: both change on the same edge.
- press_active rises on the edge after the rise is detected (E1 of the press sample) and falls with the click or cancel.
- Press and release one cycle apart (rise then fall on consecutive stage-1 samples) is a valid click.
- rst mid-press: everything returns to reset values on the next edge and any pending click is discarded.
- Geometry or enable changes take effect on the next E0 sample. No shadowing.

## Test plan
- **Basic click.** N_RECT = 4, rect0 = (100,100,50,50), all enabled. Cursor (125,125), left 0→1, hold 3 cycles, then 1→0. Expect click_pulse = 4'b0001 for one cycle, 2 edges after the release sample; sel_idx = 0; sel_valid = 1.
- **Overlap priority.** rect0 = (100,100,50,50), rect1 = (120,120,50,50).
  - Cursor (130,130): hover_idx = 0.
  - Cursor (160,160): hover_idx = 1; a click there gives click_pulse = 4'b0010.
- **Inclusive boundaries.** Cursor at (150,150) hits rect0. Cursor at (151,150) and at (100,99) do not hit rect0.
- **Drag-off cancel.** Press at (125,125), move to (300,300), release. No click_pulse; sel unchanged. Press outside, drag onto rect0, release: BLOCKED, no click.
- **Disable while armed.** Press on rect2, clear rect_enable[2], release on rect2. No click; state goes BLOCKED then IDLE.
- **Reset with button held.** Hold left = 1 across rst, then release. No click. A fresh press/release on rect3 afterwards gives click_pulse = 4'b1000 and sel_idx = 3.
